sdram_slot_arbiter: RTL and testbench



---
 rtl/sdram_slot_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sdram_slot_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_slot_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_slot_arbiter
//
// Time-slot arbiter in front of the Apple II SDRAM controller. The 112 MHz
// clk is cut into 8-cycle slots aligned to the 14 MHz clkref. Slots alternate
// A (CPU/video) and B (DMA). The request for slot N is registered onto the
// sd_* outputs at LAUNCH_PHASE of slot N-1, so the controller sees it stable
// for a whole slot. At RD_PHASE the addressed byte of sd_dout is captured
// and returned to whichever port owns the slot.
//
// Optional feature (macro SDRAM_ARB_STEAL_EN): a pending DMA request may
// also take an A slot when the CPU does not want it.
//
// Ports
//   clk, init_n          112 MHz clock, synchronous active-low reset
//   clkref               14 MHz slot reference (sampled in clk)
//   cpu_en/addr/we/din   CPU request for the upcoming A slot
//   cpu_dout             CPU read data, held between updates
//   dma_req/addr/we/din  single-cycle DMA request strobe and fields
//   dma_busy             DMA request pending or in flight
//   dma_valid            one-cycle DMA completion pulse
//   dma_dout             DMA read data, held after dma_valid
//   sd_addr/din/we/aux   request to the SDRAM controller
//   sd_dout              16-bit read data from the controller
// -----------------------------------------------------------------------------
module sdram_slot_arbiter #(
    parameter int RD_PHASE     = 6,
    parameter int LAUNCH_PHASE = 7
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        clkref,
    input  logic        cpu_en,
    input  logic [24:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic        dma_req,
    input  logic [24:0] dma_addr,
    input  logic        dma_we,
    input  logic [7:0]  dma_din,
    output logic        dma_busy,
    output logic        dma_valid,
    output logic [7:0]  dma_dout,
    output logic [24:0] sd_addr,
    output logic [7:0]  sd_din,
    output logic        sd_we,
    output logic        sd_aux,
    input  logic [15:0] sd_dout
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam logic [2:0] RD_PH     = 3'(RD_PHASE);
    localparam logic [2:0] LAUNCH_PH = 3'(LAUNCH_PHASE);

    logic        clkref_q;
    logic [2:0]  phase;
    logic        slot_b;       // 0: A slot (CPU), 1: B slot (DMA)
    owner_t      owner;        // owner of the request currently on sd_*
    logic [24:0] dma_addr_q;
    logic        dma_we_q;
    logic [7:0]  dma_din_q;

    logic        ref_edge;
    logic [2:0]  phase_next;
    logic        at_launch;
    logic        next_slot_b;
    logic        dma_pending;
    logic        dma_slot_ok;
    logic        launch_cpu;
    logic        launch_dma;
    logic [7:0]  rd_byte;

    assign ref_edge    = clkref & ~clkref_q;
    assign phase_next  = ref_edge ? 3'd0 : phase + 3'd1;
    assign at_launch   = (phase == LAUNCH_PH);
    assign next_slot_b = ~slot_b;

    // A latched request that has already been launched is in flight, not
    // pending; it must not be launched a second time.
    assign dma_pending = dma_busy & (owner != OWN_DMA);

`ifdef SDRAM_ARB_STEAL_EN
    assign dma_slot_ok = next_slot_b | ~cpu_en;
`else
    assign dma_slot_ok = next_slot_b;
`endif

    assign launch_cpu = at_launch & ~next_slot_b & cpu_en;
    assign launch_dma = at_launch & dma_pending & dma_slot_ok & ~launch_cpu;

    assign sd_aux  = sd_addr[0];
    assign rd_byte = sd_aux ? sd_dout[15:8] : sd_dout[7:0];

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register sees
        // the values from before this edge regardless of statement order.
        // clkref_q keeps sampling during reset so that a clkref already high
        // at release is not mistaken for a fresh rising edge.
        clkref_q <= clkref;

        if (!init_n) begin
            phase      <= 3'd0;
            slot_b     <= 1'b0;
            owner      <= OWN_NONE;
            dma_busy   <= 1'b0;
            dma_valid  <= 1'b0;
            dma_dout   <= 8'h00;
            cpu_dout   <= 8'h00;
            dma_addr_q <= '0;
            dma_we_q   <= 1'b0;
            dma_din_q  <= 8'h00;
            sd_addr    <= '0;
            sd_din     <= 8'h00;
            sd_we      <= 1'b0;
        end else begin
            phase <= phase_next;
            // Every entry into phase 0 starts a new slot, including the
            // short slot created by a mid-slot clkref resync.
            if (phase_next == 3'd0)
                slot_b <= ~slot_b;

            dma_valid <= 1'b0;

            if (dma_req && !dma_busy) begin
                dma_addr_q <= dma_addr;
                dma_we_q   <= dma_we;
                dma_din_q  <= dma_din;
                dma_busy   <= 1'b1;
            end

            // Capture retires the owner, so a slot shortened by a resync
            // before RD_PHASE is completed exactly once in the next slot.
            if (phase == RD_PH && owner != OWN_NONE) begin
                if (owner == OWN_CPU && !sd_we)
                    cpu_dout <= rd_byte;
                if (owner == OWN_DMA) begin
                    if (!sd_we)
                        dma_dout <= rd_byte;
                    dma_valid <= 1'b1;
                    dma_busy  <= 1'b0;
                end
                owner <= OWN_NONE;
            end

            if (launch_cpu) begin
                sd_addr <= cpu_addr;
                sd_din  <= cpu_din;
                sd_we   <= cpu_we;
                owner   <= OWN_CPU;
            end else if (launch_dma) begin
                sd_addr <= dma_addr_q;
                sd_din  <= dma_din_q;
                sd_we   <= dma_we_q;
                owner   <= OWN_DMA;
            end else if (at_launch) begin
                // Idle read: keep the address, just drop the write.
                sd_we <= 1'b0;
                owner <= OWN_NONE;
            end
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_slot_arbiter;

    logic        clk = 1'b0;
    logic        init_n, clkref, cpu_en, cpu_we, dma_req, dma_we;
    logic [24:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_din, dma_din;
    logic [15:0] sd_dout;
    logic [7:0]  cpu_dout, dma_dout, sd_din;
    logic        dma_busy, dma_valid, sd_we, sd_aux;
    logic [24:0] sd_addr;

    always #4 clk = ~clk;

    sdram_slot_arbiter dut (
        .clk(clk), .init_n(init_n), .clkref(clkref),
        .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we),
        .dma_din(dma_din), .dma_busy(dma_busy), .dma_valid(dma_valid),
        .dma_dout(dma_dout),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we),
        .sd_aux(sd_aux), .sd_dout(sd_dout)
    );

`ifdef SDRAM_ARB_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase is derived arithmetically from the edge index of the last slot
    // start; slots are counted; a DMA job lives in a queue until completion.
    typedef enum int {O_NONE, O_CPU, O_DMA} own_e;
    typedef struct {own_e owner; logic [24:0] addr; logic we; logic [7:0] din;} bus_t;
    typedef struct {logic [24:0] addr; logic we; logic [7:0] din;} job_t;

    bus_t        m_bus;
    job_t        m_jobs[$];
    bit          m_launched;
    int          m_k = 0;         // index of the next clock edge
    int          m_zero_k = 0;    // edge index whose pre-edge phase is 0
    int          m_slot_cnt = 0;  // slots since reset; even = A
    bit          m_ref_prev = 0;
    logic [7:0]  m_cpu_dout, m_dma_dout;
    bit          m_valid;

    function automatic int cur_ph();
        return (m_k - m_zero_k) % 8;
    endfunction

    function automatic bit cur_b();
        return (m_slot_cnt % 2) == 1;
    endfunction

    task automatic model_edge();
        int ph;
        bit busy_before, pend, next_b;
        logic [7:0] byt;
        if (!init_n) begin
            m_zero_k = m_k + 1;
            m_slot_cnt = 0;
            m_jobs.delete();
            m_launched = 0;
            m_bus = '{O_NONE, 25'd0, 1'b0, 8'd0};
            m_cpu_dout = 8'd0;
            m_dma_dout = 8'd0;
            m_valid = 0;
        end else begin
            ph = cur_ph();
            busy_before = m_jobs.size() != 0;
            pend = busy_before && !m_launched;
            m_valid = 0;
            if (ph == 6 && m_bus.owner != O_NONE) begin
                byt = m_bus.addr[0] ? sd_dout[15:8] : sd_dout[7:0];
                if (m_bus.owner == O_CPU && !m_bus.we) m_cpu_dout = byt;
                if (m_bus.owner == O_DMA) begin
                    if (!m_bus.we) m_dma_dout = byt;
                    m_valid = 1;
                    void'(m_jobs.pop_front());
                    m_launched = 0;
                end
                m_bus.owner = O_NONE;
            end
            if (ph == 7) begin
                next_b = !cur_b();
                if (!next_b && cpu_en) begin
                    m_bus = '{O_CPU, cpu_addr, cpu_we, cpu_din};
                end else if (pend && (next_b || (STEAL && !cpu_en))) begin
                    m_bus = '{O_DMA, m_jobs[0].addr, m_jobs[0].we, m_jobs[0].din};
                    m_launched = 1;
                end else begin
                    m_bus.owner = O_NONE;
                    m_bus.we = 1'b0;
                end
            end
            if (dma_req && !busy_before) m_jobs.push_back('{dma_addr, dma_we, dma_din});
            if (clkref && !m_ref_prev) m_zero_k = m_k + 1;
            if (((m_k + 1 - m_zero_k) % 8) == 0) m_slot_cnt++;
        end
        m_ref_prev = clkref;
        m_k++;
    endtask

    // One clock: the model consumes the same inputs the DUT sampled, then
    // all outputs are compared 1 ns after the edge.
    task automatic step();
        logic [60:0] exp_v;
        @(posedge clk);
        model_edge();
        #1;
        exp_v = {m_bus.addr, m_bus.din, m_bus.we, m_bus.addr[0], m_cpu_dout,
                 m_dma_dout, m_valid, (m_jobs.size() != 0)};
        check($sformatf("outputs@edge%0d", m_k - 1),
              {sd_addr, sd_din, sd_we, sd_aux, cpu_dout, dma_dout, dma_valid, dma_busy}, exp_v);
    endtask

    int ref_cnt = 0;
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            clkref = (ref_cnt % 8) < 4;
            ref_cnt++;
            step();
        end
    endtask

    task automatic wait_slot(input int ph, input bit b);
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (cur_ph() == ph && cur_b() == b) found = 1;
            else run(1);
        end
        check("wait_slot_budget", found, 1);
    endtask

    task automatic wait_valid(input int budget, output int n, output bit seen);
        seen = 0;
        n = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            run(1);
            n++;
            if (dma_valid) seen = 1;
        end
    endtask

    typedef struct {
        logic [24:0] addr; logic we; logic [7:0] din; logic [15:0] dout;
        logic [7:0] exp_cpu; logic exp_aux;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, cnt;
        bit seen;
        init_n = 0; clkref = 0; cpu_en = 0; cpu_addr = '0; cpu_we = 0; cpu_din = '0;
        dma_req = 0; dma_addr = '0; dma_we = 0; dma_din = '0; sd_dout = '0;
        run(4);
        check("reset_outputs",
              {sd_addr, sd_din, sd_we, sd_aux, cpu_dout, dma_dout, dma_valid, dma_busy}, 61'd0);
        init_n = 1;
        run(16);

        // ---- table-driven CPU reads/writes ----
        vecs[0] = '{25'h0001234, 1'b0, 8'h00, 16'hBEEF, 8'hEF, 1'b0};
        vecs[1] = '{25'h0001235, 1'b0, 8'h00, 16'hBEEF, 8'hBE, 1'b1};
        vecs[2] = '{25'h1FFFFFF, 1'b0, 8'h00, 16'h1234, 8'h12, 1'b1};
        vecs[3] = '{25'h0000010, 1'b1, 8'h77, 16'h1299, 8'h12, 1'b0};
        vecs[4] = '{25'h0000000, 1'b0, 8'h00, 16'h00FF, 8'hFF, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cpu_en = 1; cpu_addr = vecs[i].addr; cpu_we = vecs[i].we;
            cpu_din = vecs[i].din; sd_dout = vecs[i].dout;
            run(24);
            check($sformatf("vec%0d_cpu_dout", i), cpu_dout, vecs[i].exp_cpu);
            check($sformatf("vec%0d_sd_aux", i), sd_aux, vecs[i].exp_aux);
            check($sformatf("vec%0d_sd_addr", i), sd_addr, vecs[i].addr);
        end
        cpu_en = 0; cpu_we = 0;
        run(24);

        // ---- DMA write, plus a second request while busy ----
        dma_addr = 25'h0400000; dma_we = 1; dma_din = 8'h5A; dma_req = 1;
        run(1);
        dma_req = 0;
        check("dma_busy_set", dma_busy, 1);
        run(2);
        dma_addr = 25'h0000099; dma_we = 0; dma_req = 1;
        run(1);
        dma_req = 0;
        cnt = 0; seen = 0;
        for (int i = 0; i < 80; i++) begin
            run(1);
            if (dma_valid) cnt++;
            if (sd_we && sd_din == 8'h5A && sd_addr == 25'h0400000) seen = 1;
        end
        check("dma_wr_valid_count", cnt, 1);
        check("dma_wr_on_bus", seen, 1);
        check("dma_wr_busy_clear", dma_busy, 0);

        // ---- DMA read of an odd byte ----
        sd_dout = 16'hC3A5;
        dma_addr = 25'h0000003; dma_we = 0; dma_req = 1;
        run(1);
        dma_req = 0;
        wait_valid(40, n, seen);
        check("dma_rd_valid_seen", seen, 1);
        check("dma_rd_dout", dma_dout, 8'hC3);

        // ---- request at B phase 0: steal serves it in the A slot ----
        cpu_en = 0;
        wait_slot(0, 1);
        dma_addr = 25'h0000007; dma_req = 1;
        run(1);
        dma_req = 0;
        wait_valid(40, n, seen);
        check("dma_latency_from_b0", n, STEAL ? 14 : 22);

        // ---- request at A launch phase: waits a full A/B pair ----
        cpu_en = 1; cpu_addr = 25'h0000100;
        wait_slot(7, 0);
        dma_addr = 25'h0000008; dma_req = 1;
        run(1);
        dma_req = 0;
        wait_valid(40, n, seen);
        check("dma_latency_from_a7", n, 23);

        // ---- clkref edge at phase 3 of an A slot ----
        cpu_en = 1; cpu_addr = 25'h0000AAA;
        run(20);
        wait_slot(1, 0);
        clkref = 0;
        step();
        step();
        clkref = 1; cpu_addr = 25'h0000555;
        step();
        check("resync_fields_kept", sd_addr, 25'h0000AAA);
        for (int i = 0; i < 7; i++) step();
        check("resync_no_early_launch", sd_addr, 25'h0000AAA);
        step();
        check("resync_slot_toggled", sd_addr, 25'h0000555);
        ref_cnt = 0;
        run(8);

        // ---- reset between a DMA launch and its capture ----
        cpu_en = 0;
        dma_addr = 25'h0000050; dma_we = 0; dma_req = 1;
        run(1);
        dma_req = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            run(1);
            if (m_launched) seen = 1;
        end
        check("mid_dma_launched", seen, 1);
        run(2);
        init_n = 0;
        run(2);
        check("mid_dma_reset_outputs",
              {sd_addr, sd_din, sd_we, sd_aux, cpu_dout, dma_dout, dma_valid, dma_busy}, 61'd0);
        init_n = 1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            run(1);
            if (dma_valid) cnt++;
        end
        check("mid_dma_no_valid", cnt, 0);
        check("mid_dma_busy_clear", dma_busy, 0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            cpu_en   = ($urandom_range(0, 9) < 7);
            cpu_addr = 25'($urandom);
            cpu_we   = ($urandom_range(0, 3) == 0);
            cpu_din  = 8'($urandom);
            dma_req  = ($urandom_range(0, 9) == 0);
            dma_addr = 25'($urandom);
            dma_we   = $urandom_range(0, 1) == 1;
            dma_din  = 8'($urandom);
            sd_dout  = 16'($urandom);
            init_n   = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 49) == 0) ref_cnt = $urandom_range(0, 7);
            run(1);
        end
        init_n = 1; dma_req = 0;
        run(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
